// File: rtl/deser_bitslip_align_pkg.sv
// Shared definitions for the HiSPi word-alignment controller: state encodings,
// default training pattern and counter width helper.
package deser_bitslip_align_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COMPARE = 3'd1;
    localparam logic [2:0] ST_SLIP    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;
    localparam logic [2:0] ST_FAIL    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_COMPARE = ST_COMPARE,
        S_SLIP    = ST_SLIP,
        S_WAIT    = ST_WAIT,
        S_LOCKED  = ST_LOCKED,
        S_FAIL    = ST_FAIL
    } state_e;

    // Also consumed by the lane-merge stage, so keep it in one place.
    localparam logic [5:0] HISPI_TRAIN_PAT = 6'b111000;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/deser_bitslip_align_if.sv
// Lane-side bundle between the ISERDES2 word path, the alignment controller
// and its downstream consumer.
interface deser_bitslip_align_if #(
    parameter int DESER_WIDTH = 6
);
    logic                   align_en;
    logic [DESER_WIDTH-1:0] iv_data;
    logic                   o_bitslip;
    logic                   o_locked;
    logic                   o_align_fail;
    logic [3:0]             ov_slip_cnt;
    logic [DESER_WIDTH-1:0] ov_data;
    logic                   o_data_valid;

    modport master (
        output align_en, iv_data,
        input  o_bitslip, o_locked, o_align_fail, ov_slip_cnt, ov_data, o_data_valid
    );

    modport slave (
        input  align_en, iv_data,
        output o_bitslip, o_locked, o_align_fail, ov_slip_cnt, ov_data, o_data_valid
    );
endinterface

// File: rtl/deser_bitslip_align.sv
// Word-alignment controller for one HiSPi lane: slips the ISERDES2 until the
// training pattern is seen MATCH_COUNT times in a row, then passes data on.
module deser_bitslip_align
    import deser_bitslip_align_pkg::*;
#(
    parameter int                     DESER_WIDTH      = 6,
    parameter logic [DESER_WIDTH-1:0] TRAINING_PATTERN = DESER_WIDTH'(HISPI_TRAIN_PAT),
    parameter int                     MATCH_COUNT      = 16,
    parameter int                     SLIP_WAIT        = 4,
    parameter int                     MAX_SLIP         = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    deser_bitslip_align_if.slave  bus
);

    localparam int MW = clog2(MATCH_COUNT);
    localparam int WW = clog2(SLIP_WAIT);
    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
    localparam logic [3:0]    SLIP_MAX   = 4'(MAX_SLIP);

    state_e                 r_state, w_state_nxt;
    logic [MW-1:0]          r_match_cnt, w_match_nxt;
    logic [WW-1:0]          r_wait_cnt, w_wait_nxt;
    logic [3:0]             r_slip_cnt, w_slip_nxt;
    logic [DESER_WIDTH-1:0] r_data;
    logic                   r_data_valid;
    logic                   w_match;

    assign w_match = (bus.iv_data == TRAINING_PATTERN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_match_cnt <= '0;
            r_wait_cnt  <= '0;
            r_slip_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_slip_cnt  <= w_slip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_slip_nxt  = r_slip_cnt;
        case (r_state)
            S_IDLE: begin
                w_slip_nxt  = '0;
                w_match_nxt = '0;
                w_state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                if (w_match) begin
                    if (r_match_cnt == MATCH_LAST) w_state_nxt = S_LOCKED;
                    else                           w_match_nxt = r_match_cnt + 1'b1;
                end else begin
                    w_match_nxt = '0;
                    w_state_nxt = (r_slip_cnt == SLIP_MAX) ? S_FAIL : S_SLIP;
                end
            end
            S_SLIP: begin
                w_slip_nxt  = r_slip_cnt + 1'b1;
                w_wait_nxt  = '0;
                w_state_nxt = S_WAIT;
            end
            // Words during the settle window come from an unstable phase.
            S_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_match_nxt = '0;
                    w_state_nxt = S_COMPARE;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            S_LOCKED, S_FAIL: ;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!bus.align_en) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data       <= bus.iv_data;
            r_data_valid <= (r_state == S_LOCKED);
        end
    end

    assign bus.o_bitslip    = (r_state == S_SLIP);
    assign bus.o_locked     = (r_state == S_LOCKED);
    assign bus.o_align_fail = (r_state == S_FAIL);
    assign bus.ov_slip_cnt  = r_slip_cnt;
    assign bus.ov_data      = r_data;
    assign bus.o_data_valid = r_data_valid;

endmodule

// File: doc/deser_bitslip_align.md
Name: deser_bitslip_align

Overview:
- Word-alignment controller for one HiSPi deserializer lane, running in the recovered parallel clock domain (BUFG-driven clk_recover from the deser clock generator).
- Consumes the ISERDES2 parallel word and compares it against a training pattern.
- On mismatch, pulses bitslip back to the ISERDES2 and waits for it to settle, until the pattern matches for a required run length.
- Then reports lock and passes data downstream; reports failure if every bit phase has been tried without success.

Parameters:
- DESER_WIDTH, 6, parallel word width per lane, 2..8; must equal the deser clock generator's DESER_WIDTH.
- TRAINING_PATTERN, 6'b111000, expected aligned word during training; width DESER_WIDTH.
- MATCH_COUNT, 16, consecutive matching words required for lock, 1..255.
- SLIP_WAIT, 4, cycles ignored after each bitslip pulse, 1..15.
- MAX_SLIP, 6, maximum bitslip pulses before failure, 1..15.

Ports:
- clk  input  1  recovered parallel clock (clk_recover).
- reset_n  input  1  asynchronous active-low reset.
- align_en  input  1  level; 1 runs alignment, 0 returns to IDLE.
- iv_data  input  DESER_WIDTH  ISERDES2 parallel output.
- o_bitslip  output  1  one-cycle bitslip request to ISERDES2.
- o_locked  output  1  alignment achieved.
- o_align_fail  output  1  all phases tried, no lock.
- ov_slip_cnt  output  4  bitslip pulses issued since alignment start.
- ov_data  output  DESER_WIDTH  iv_data registered by one cycle.
- o_data_valid  output  1  ov_data is aligned payload.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs 0.
  - match_cnt=0, slip_cnt=0, wait_cnt=0.
- States: IDLE, COMPARE, SLIP, WAIT, LOCKED, FAIL; state register is a flop; o_locked=(state==LOCKED) and o_align_fail=(state==FAIL), both decoded from the state register.
- align_en=0 in any state: next state IDLE; highest priority over every other transition.
- IDLE: slip_cnt=0, match_cnt=0. If align_en=1, go to COMPARE next cycle.
- COMPARE: one sample per cycle, iv_data compared against TRAINING_PATTERN.
  - Match with match_cnt<MATCH_COUNT-1: match_cnt++.
  - Match with match_cnt==MATCH_COUNT-1: go to LOCKED. o_locked rises on the cycle after the MATCH_COUNT-th consecutive match.
  - Mismatch with slip_cnt<MAX_SLIP: go to SLIP, match_cnt=0.
  - Mismatch with slip_cnt==MAX_SLIP: go to FAIL.
- SLIP: o_bitslip=1 for exactly this one cycle; slip_cnt++, wait_cnt=0; go to WAIT.
  - o_bitslip is never high in any other state.
  - o_bitslip is never high two cycles in a row.
- WAIT: iv_data ignored; wait_cnt++. When wait_cnt==SLIP_WAIT-1, go to COMPARE with match_cnt=0. WAIT lasts exactly SLIP_WAIT cycles.
- LOCKED: held while align_en=1; data is not re-checked. slip_cnt is frozen and visible on ov_slip_cnt.
- FAIL: held while align_en=1; no further bitslips. Retry is done by dropping align_en for at least one cycle.
- ov_slip_cnt = slip_cnt, zero-extended to 4 bits. It saturates by construction at MAX_SLIP and never wraps.
- Datapath:
  - ov_data <= iv_data every cycle, regardless of state.
  - o_data_valid <= (state==LOCKED), so it lags o_locked by one cycle, aligned with ov_data.
- ISERDES2 bit phase is not reset by this block. Re-alignment after IDLE continues from the current phase.
- align_en dropped mid-SLIP: the pulse already in progress completes (it is a single cycle); then IDLE.

Decomposition:
- Shared include/package holds:
  - state encodings (3-bit localparams: IDLE=0, COMPARE=1, SLIP=2, WAIT=3, LOCKED=4, FAIL=5);
  - a clog2 function for match_cnt/wait_cnt widths;
  - the default HiSPi training pattern constant, shared with the lane-merge stage.
- Single module; no sub-module. Multi-lane use instantiates one per lane.

Test Plan:
- Bench ISERDES model: rotates the serial stream by one bit per o_bitslip. Parameters: DESER_WIDTH=6, pattern 6'b111000, MATCH_COUNT=16, SLIP_WAIT=4, MAX_SLIP=6.
- Stream already aligned, align_en rises at cycle 0 -> COMPARE at cycle 1; o_locked=1 at cycle 17; o_data_valid=1 at cycle 18; ov_slip_cnt=0; o_bitslip never asserted.
- Stream offset by 3 bits -> exactly 3 single-cycle o_bitslip pulses, each followed by 4 ignored cycles; then lock with ov_slip_cnt=3.
- Stream never matches (constant 6'b101010) -> 6 bitslip pulses, then o_align_fail=1, o_locked=0, ov_slip_cnt=6; no further pulses while align_en=1.
- Aligned stream with one corrupted word at match 10 -> slip issued, match_cnt restarts from 0; lock requires 16 fresh consecutive matches.
- align_en dropped in WAIT and while LOCKED -> IDLE next cycle; o_locked=0, o_data_valid=0 one cycle later; re-raising align_en restarts with ov_slip_cnt=0.
- reset_n asserted mid-COMPARE, asynchronously between clock edges -> all outputs 0 immediately; after release, stays IDLE until align_en=1.
